// File: rtl/mips_cycle_sequencer.sv
// Multicycle FETCH/EXEC/MEM control sequencer for the MIPS core, with a halt
// address, Avalon-style wait_req stalling and an optional bus-timeout watchdog.
module mips_cycle_sequencer #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] HALT_ADDR   = '0,
    parameter int                OPC_W       = 6,
    parameter int                MEM_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wait_req,
    input  logic [ADDR_W-1:0] pc,
    input  logic [OPC_W-1:0]  opcode,
    output logic [2:0]        state,
    output logic              active,
    output logic              mem_read,
    output logic              mem_write,
    output logic              ir_load,
    output logic              pc_update,
    output logic              reg_write,
    output logic              mem_stall,
    output logic              bus_error
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? (($clog2(MEM_TIMEOUT + 1) > 0) ? $clog2(MEM_TIMEOUT + 1) : 1) : 1;
    localparam bit WD_EN = (MEM_TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_HALT  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
    logic             bus_error_reg, bus_error_next;
    logic             is_load, is_store, wd_expire;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        case (opcode)
            OPC_W'(6'b100000), OPC_W'(6'b100001), OPC_W'(6'b100010), OPC_W'(6'b100011),
            OPC_W'(6'b100100), OPC_W'(6'b100101), OPC_W'(6'b100110): is_load = 1'b1;
            OPC_W'(6'b101000), OPC_W'(6'b101001), OPC_W'(6'b101010), OPC_W'(6'b101011),
            OPC_W'(6'b101110): is_store = 1'b1;
            default: ;
        endcase
    end

    // Saturating busy counter; expiry fires on the MEM_TIMEOUT-th busy cycle.
    assign cnt_inc   = (cnt_reg == '1) ? cnt_reg : cnt_reg + CNT_W'(1);
    assign wd_expire = WD_EN && wait_req && (cnt_reg == CNT_LAST);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bus_error_next = bus_error_reg;
        active         = 1'b1;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        ir_load        = 1'b0;
        pc_update      = 1'b0;
        reg_write      = 1'b0;
        mem_stall      = 1'b0;
        case (state_reg)
            S_FETCH: begin
                if (pc == HALT_ADDR) begin
                    state_next = S_HALT;
                    cnt_next   = '0;
                end else begin
                    mem_read = 1'b1;
                    if (wait_req) begin
                        mem_stall = 1'b1;
                        if (wd_expire) begin
                            state_next     = S_ERROR;
                            bus_error_next = 1'b1;
                            cnt_next       = '0;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else begin
                        ir_load    = 1'b1;
                        state_next = S_EXEC;
                        cnt_next   = '0;
                    end
                end
            end
            S_EXEC: begin
                pc_update = 1'b1;
                cnt_next  = '0;
                if (is_load || is_store) begin
                    state_next = S_MEM;
                end else begin
                    reg_write  = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_MEM: begin
                mem_read  = is_load;
                mem_write = is_store && !is_load;
                if (wait_req) begin
                    mem_stall = 1'b1;
                    if (wd_expire) begin
                        state_next     = S_ERROR;
                        bus_error_next = 1'b1;
                        cnt_next       = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end else begin
                    reg_write  = is_load;
                    state_next = S_FETCH;
                    cnt_next   = '0;
                end
            end
            S_HALT: begin
                active   = 1'b0;
                cnt_next = '0;
            end
            S_ERROR: begin
                active   = 1'b0;
                cnt_next = '0;
            end
            default: begin
                state_next = S_FETCH;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_FETCH;
            cnt_reg       <= '0;
            bus_error_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bus_error_reg <= bus_error_next;
        end
    end

    assign state     = state_reg;
    assign bus_error = bus_error_reg;

endmodule
